max7219_chain_sequencer: RTL and testbench

Parametrised successor to the single-device MAX7219 settings writer. It drives a daisy-chain of N_DEV MAX7219 devices through the existing SPI driver. Each SPI transaction carries one 16-bit word per device. The block has three operating modes:
- single-digit write
- full config broadcast
- full display refresh read from an external framebuffer

It sits between the clock/display logic and the SPI driver.

---
 rtl/max7219_pkg.sv | 52 +++++
 rtl/max7219_frame_builder.sv | 49 ++++
 rtl/max7219_chain_sequencer.sv | 171 +++++++++++++++++
 tb/tb_max7219_chain_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared MAX7219 register map, mode/state encodings and word-packing helpers.
package max7219_pkg;

    localparam logic [3:0] REG_NOOP         = 4'h0;
    localparam logic [3:0] REG_DIGIT0       = 4'h1;
    localparam logic [3:0] REG_DECODE       = 4'h9;
    localparam logic [3:0] REG_INTENSITY    = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
    localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

    localparam int CFG_FRAMES = 5;

    typedef enum logic [1:0] {
        MODE_SINGLE  = 2'd0,
        MODE_CONFIG  = 2'd1,
        MODE_REFRESH = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUILD,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [7:0] decode;
        logic [3:0] intensity;
        logic [2:0] scan_limit;
        logic       enable;
        logic       display_test;
    } cfg_t;

    function automatic logic [15:0] pack_word(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

    // Config frames go out in register order: decode, intensity, scan, shutdown, test.
    function automatic logic [15:0] cfg_word(input logic [2:0] idx, input cfg_t cfg);
        case (idx)
            3'd0:    return pack_word(REG_DECODE, cfg.decode);
            3'd1:    return pack_word(REG_INTENSITY, {4'h0, cfg.intensity});
            3'd2:    return pack_word(REG_SCAN_LIMIT, {5'h0, cfg.scan_limit});
            3'd3:    return pack_word(REG_SHUTDOWN, {7'h0, cfg.enable});
            default: return pack_word(REG_DISPLAY_TEST, {7'h0, cfg.display_test});
        endcase
    endfunction

endpackage

// File: rtl/max7219_frame_builder.sv
// Registered chain frame: broadcast, single-target (others no-op) or per-slot load.
// Updates one cycle after a control strobe; no flow control, the sequencer owns timing.
module max7219_frame_builder
    import max7219_pkg::*;
#(
    parameter int N_DEV  = 2,
    parameter int DEV_W  = 3,
    parameter int SLOT_W = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 bcast_i,
    input  logic                 target_i,
    input  logic                 slot_ld_i,
    input  logic [DEV_W-1:0]     dev_i,
    input  logic [SLOT_W-1:0]    slot_i,
    input  logic [15:0]          word_i,
    output logic [16*N_DEV-1:0]  frame_o
);

    localparam logic [15:0] NOOP_WORD = pack_word(REG_NOOP, 8'h00);

    logic [16*N_DEV-1:0] frame_q, frame_d;

    // An out-of-range target simply matches no slot, so the whole frame becomes no-ops.
    always_comb begin
        frame_d = frame_q;
        for (int k = 0; k < N_DEV; k++) begin
            if (bcast_i) begin
                frame_d[16*k +: 16] = word_i;
            end else if (target_i) begin
                frame_d[16*k +: 16] = (int'(dev_i) == k) ? word_i : NOOP_WORD;
            end else if (slot_ld_i && (int'(slot_i) == k)) begin
                frame_d[16*k +: 16] = word_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame_o = frame_q;

endmodule

// File: rtl/max7219_chain_sequencer.sv
// Sequences single/config/refresh writes to a chain of MAX7219s; one frame per SPI transaction.
// Frame ready 1 cycle (BUILD) or N_DEV+1 cycles (LOAD) after start; SEND holds until i_next.
module max7219_chain_sequencer
    import max7219_pkg::*;
#(
    parameter int N_DEV    = 2,
    parameter int N_DIGITS = 8,
    parameter int FB_AW    = 4,
    parameter int DEV_W    = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_stb,
    input  logic [1:0]           i_mode,
    input  logic [DEV_W-1:0]     i_dev,
    input  logic [2:0]           i_digit,
    input  logic [7:0]           i_segment,
    input  logic [7:0]           i_decode_mode,
    input  logic [3:0]           i_intensity,
    input  logic [2:0]           i_scan_limit,
    input  logic                 i_enable,
    input  logic                 i_display_test,
    output logic [FB_AW-1:0]     o_fb_addr,
    input  logic [7:0]           i_fb_data,
    output logic                 o_write,
    input  logic                 i_next,
    output logic [16*N_DEV-1:0]  o_frame,
    output logic                 o_busy,
    output logic                 o_ack
);

    localparam int FCNT_W = 3;
    localparam int DCNT_W = $clog2(N_DEV + 1);

    state_e              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [FB_AW-1:0]    fb_addr_q, fb_addr_live;

    mode_e               mode_q;
    logic [DEV_W-1:0]    dev_q;
    logic [2:0]          digit_q;
    logic [7:0]          seg_q;
    cfg_t                cfg_q;

    logic                accept;
    logic                last_frame;
    logic                fetch_vld;
    logic                bcast, target, slot_ld;
    logic [DCNT_W-1:0]   slot;
    logic [15:0]         word;

    assign accept = (state_q == ST_IDLE) && i_stb;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            fcnt_q    <= '0;
            dcnt_q    <= '0;
            fb_addr_q <= '0;
            mode_q    <= MODE_SINGLE;
            dev_q     <= '0;
            digit_q   <= '0;
            seg_q     <= '0;
            cfg_q     <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            dcnt_q  <= dcnt_d;
            if (fetch_vld) begin
                fb_addr_q <= fb_addr_live;
            end
            if (accept) begin
                mode_q  <= mode_e'(i_mode);
                dev_q   <= i_dev;
                digit_q <= i_digit;
                seg_q   <= i_segment;
                cfg_q   <= '{decode: i_decode_mode, intensity: i_intensity,
                             scan_limit: i_scan_limit, enable: i_enable,
                             display_test: i_display_test};
            end
        end
    end

    always_comb begin
        case (mode_q)
            MODE_CONFIG:  last_frame = (fcnt_q == FCNT_W'(CFG_FRAMES - 1));
            MODE_REFRESH: last_frame = (fcnt_q == FCNT_W'(N_DIGITS - 1));
            default:      last_frame = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_stb) begin
                    fcnt_d = '0;
                    dcnt_d = '0;
                    case (mode_e'(i_mode))
                        MODE_SINGLE, MODE_CONFIG: state_d = ST_BUILD;
                        MODE_REFRESH:             state_d = ST_LOAD;
                        default:                  state_d = ST_DONE;
                    endcase
                end
            end
            ST_BUILD: state_d = ST_SEND;
            ST_LOAD: begin
                // One extra cycle past the last address to catch the final byte.
                if (dcnt_q == DCNT_W'(N_DEV)) begin
                    state_d = ST_SEND;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (i_next) begin
                    if (last_frame) begin
                        state_d = ST_DONE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d  = fcnt_q + 1'b1;
                        state_d = (mode_q == MODE_REFRESH) ? ST_LOAD : ST_BUILD;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_write      = (state_q == ST_SEND);
        o_ack        = (state_q == ST_DONE);
        o_busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        fetch_vld    = (state_q == ST_LOAD) && (dcnt_q < DCNT_W'(N_DEV));
        fb_addr_live = FB_AW'(dcnt_q) * FB_AW'(N_DIGITS) + FB_AW'(fcnt_q);
        o_fb_addr    = fetch_vld ? fb_addr_live : fb_addr_q;
        bcast        = (state_q == ST_BUILD) && (mode_q == MODE_CONFIG);
        target       = (state_q == ST_BUILD) && (mode_q == MODE_SINGLE);
        slot_ld      = (state_q == ST_LOAD) && (dcnt_q != '0);
        slot         = dcnt_q - 1'b1;
        if (mode_q == MODE_CONFIG) begin
            word = cfg_word(fcnt_q, cfg_q);
        end else if (mode_q == MODE_SINGLE) begin
            word = pack_word(REG_DIGIT0 + {1'b0, digit_q}, seg_q);
        end else begin
            word = pack_word(REG_DIGIT0 + {1'b0, fcnt_q}, i_fb_data);
        end
    end

    max7219_frame_builder #(
        .N_DEV  (N_DEV),
        .DEV_W  (DEV_W),
        .SLOT_W (DCNT_W)
    ) u_builder (
        .clk_i     (i_clk),
        .reset_i   (i_reset),
        .bcast_i   (bcast),
        .target_i  (target),
        .slot_ld_i (slot_ld),
        .dev_i     (dev_q),
        .slot_i    (slot),
        .word_i    (word),
        .frame_o   (o_frame)
    );

endmodule

// File: tb/tb_max7219_chain_sequencer.sv
// Scoreboard bench: stimulus queues expected frames/acks, a negedge monitor checks DUT output.
module tb_max7219_chain_sequencer;

    localparam int N_DEV    = 2;
    localparam int N_DIGITS = 8;
    localparam int FB_AW    = 4;
    localparam int DEV_W    = 3;

    logic                i_clk = 1'b0;
    logic                i_reset, i_stb, i_enable, i_display_test, i_next;
    logic [1:0]          i_mode;
    logic [DEV_W-1:0]    i_dev;
    logic [2:0]          i_digit, i_scan_limit;
    logic [7:0]          i_segment, i_decode_mode, i_fb_data;
    logic [3:0]          i_intensity;
    logic [FB_AW-1:0]    o_fb_addr;
    logic                o_write, o_busy, o_ack;
    logic [16*N_DEV-1:0] o_frame;

    typedef struct {
        logic [31:0] frame;
        bit          chk_addr;
        logic [3:0]  addr;
    } exp_t;

    exp_t        exp_q[$];
    int          ack_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frames_seen = 0;
    int          next_delay = 0;
    logic [7:0]  fb_mem [16];

    always #5 i_clk = ~i_clk;

    max7219_chain_sequencer #(
        .N_DEV(N_DEV), .N_DIGITS(N_DIGITS), .FB_AW(FB_AW), .DEV_W(DEV_W)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_mode(i_mode),
        .i_dev(i_dev), .i_digit(i_digit), .i_segment(i_segment),
        .i_decode_mode(i_decode_mode), .i_intensity(i_intensity),
        .i_scan_limit(i_scan_limit), .i_enable(i_enable),
        .i_display_test(i_display_test), .o_fb_addr(o_fb_addr),
        .i_fb_data(i_fb_data), .o_write(o_write), .i_next(i_next),
        .o_frame(o_frame), .o_busy(o_busy), .o_ack(o_ack)
    );

    initial begin
        for (int a = 0; a < 16; a++) fb_mem[a] = 8'(a + 16);
    end

    always @(posedge i_clk) i_fb_data <= fb_mem[o_fb_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rf_frame(input int d);
        return {4'h0, 4'(d + 1), 8'(8'h18 + d), 4'h0, 4'(d + 1), 8'(8'h10 + d)};
    endfunction

    function automatic exp_t mk(input logic [31:0] f, input bit ca, input logic [3:0] a);
        exp_t e;
        e.frame = f; e.chk_addr = ca; e.addr = a;
        return e;
    endfunction

    // SPI driver stand-in: acks each frame after next_delay cycles in SEND.
    initial begin
        int wcnt = 0;
        i_next = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            if (i_next) begin
                i_next = 1'b0;
                wcnt = 0;
            end else if (o_write && !i_reset) begin
                if (wcnt >= next_delay) i_next = 1'b1;
                else wcnt++;
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        exp_t cur;
        bit   cur_ok = 1'b0;
        bit   prev_write = 1'b0;
        bit   prev_ack = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                prev_write = 1'b0;
                prev_ack   = 1'b0;
                cur_ok     = 1'b0;
            end else begin
                if (o_write && !prev_write) begin
                    frames_seen++;
                    chk("busy_in_send", o_busy, 1);
                    if (exp_q.size() == 0) begin
                        checks++; errors++; cur_ok = 1'b0;
                        $display("FAIL unexpected_frame: got %0h, expected no frame", o_frame);
                    end else begin
                        cur = exp_q.pop_front();
                        cur_ok = 1'b1;
                        chk("frame", o_frame, cur.frame);
                        if (cur.chk_addr) chk("fb_addr_hold", o_fb_addr, cur.addr);
                    end
                end else if (o_write && cur_ok) begin
                    chk("frame_stable", o_frame, cur.frame);
                end
                if (o_ack) begin
                    chk("ack_expected", ack_q.size() > 0, 1);
                    if (ack_q.size() > 0) void'(ack_q.pop_front());
                    chk("ack_not_busy", o_busy, 0);
                    chk("ack_one_cycle", prev_ack, 0);
                end
                prev_write = o_write;
                prev_ack   = o_ack;
            end
        end
    end

    task automatic issue(input logic [1:0] mode, input logic [DEV_W-1:0] dev,
                         input logic [2:0] digit, input logic [7:0] seg);
        @(posedge i_clk); #1;
        i_mode = mode; i_dev = dev; i_digit = digit; i_segment = seg; i_stb = 1'b1;
        @(posedge i_clk); #1;
        i_stb = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || ack_q.size() != 0 || o_busy) && n < 2000) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk({name, "_complete"}, n < 2000, 1);
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        i_reset = 1'b1; i_stb = 1'b0; i_mode = '0; i_dev = '0; i_digit = '0;
        i_segment = '0; i_decode_mode = '0; i_intensity = '0; i_scan_limit = '0;
        i_enable = 1'b0; i_display_test = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_write", o_write, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ack", o_ack, 0);
        chk("rst_frame", o_frame, 0);
        chk("rst_fb_addr", o_fb_addr, 0);
        i_reset = 1'b0;

        exp_q.push_back(mk(32'h035A_0000, 1'b0, 4'h0));
        ack_q.push_back(1);
        issue(2'd0, 3'd1, 3'd2, 8'h5A);
        drain("single");

        i_decode_mode = 8'hFF; i_intensity = 4'h7; i_scan_limit = 3'd7;
        i_enable = 1'b1; i_display_test = 1'b0;
        exp_q.push_back(mk(32'h09FF_09FF, 1'b0, 4'h0));
        exp_q.push_back(mk(32'h0A07_0A07, 1'b0, 4'h0));
        exp_q.push_back(mk(32'h0B07_0B07, 1'b0, 4'h0));
        exp_q.push_back(mk(32'h0C01_0C01, 1'b0, 4'h0));
        exp_q.push_back(mk(32'h0F00_0F00, 1'b0, 4'h0));
        ack_q.push_back(1);
        issue(2'd1, 3'd0, 3'd0, 8'h00);
        drain("config");

        for (int d = 0; d < N_DIGITS; d++) exp_q.push_back(mk(rf_frame(d), 1'b1, 4'(8 + d)));
        ack_q.push_back(1);
        issue(2'd2, 3'd0, 3'd0, 8'h00);
        drain("refresh");

        next_delay = 20;
        i_decode_mode = 8'h0F; i_intensity = 4'hA; i_scan_limit = 3'd3;
        i_enable = 1'b0; i_display_test = 1'b1;
        exp_q.push_back(mk(32'h090F_090F, 1'b0, 4'h0));
        exp_q.push_back(mk(32'h0A0A_0A0A, 1'b0, 4'h0));
        exp_q.push_back(mk(32'h0B03_0B03, 1'b0, 4'h0));
        exp_q.push_back(mk(32'h0C00_0C00, 1'b0, 4'h0));
        exp_q.push_back(mk(32'h0F01_0F01, 1'b0, 4'h0));
        ack_q.push_back(1);
        issue(2'd1, 3'd0, 3'd0, 8'h00);
        repeat (3) @(posedge i_clk);
        i_intensity = 4'h1;
        issue(2'd0, 3'd0, 3'd0, 8'h11);
        drain("backpressure");
        next_delay = 0;

        next_delay = 5;
        base = frames_seen;
        for (int d = 0; d < 4; d++) exp_q.push_back(mk(rf_frame(d), 1'b1, 4'(8 + d)));
        issue(2'd2, 3'd0, 3'd0, 8'h00);
        n = 0;
        while (frames_seen < base + 4 && n < 2000) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("reach_frame3", n < 2000, 1);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        chk("abort_write", o_write, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_ack", o_ack, 0);
        chk("abort_frame", o_frame, 0);
        chk("abort_fb_addr", o_fb_addr, 0);
        i_reset = 1'b0;
        next_delay = 0;
        exp_q.push_back(mk(32'h0000_08C3, 1'b0, 4'h0));
        ack_q.push_back(1);
        issue(2'd0, 3'd0, 3'd7, 8'hC3);
        drain("post_reset_single");

        ack_q.push_back(1);
        issue(2'd3, 3'd0, 3'd0, 8'h00);
        drain("mode3");

        exp_q.push_back(mk(32'h0000_0000, 1'b0, 4'h0));
        ack_q.push_back(1);
        issue(2'd0, 3'd5, 3'd1, 8'hFF);
        drain("dev_out_of_range");

        chk("frames_left", exp_q.size(), 0);
        chk("acks_left", ack_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
